// File: rtl/wdt_pkg.sv
// Shared constants and state encoding for the second-generation watchdog counter core.
package wdt_pkg;

    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned PRE_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF = 12;

    localparam int unsigned LOAD_ADDR = 32'h000;

    typedef enum logic [1:0] {
        ARMED        = 2'd0,
        INT_PEND     = 2'd1,
        RST_ASSERTED = 2'd2
    } wdt_state_e;

    localparam wdt_state_e STATE_RST = ARMED;
    localparam logic       INT_RST   = 1'b0;
    localparam logic       REQ_RST   = 1'b0;

    // Counter and load both come out of reset at the maximum period.
    function automatic logic [CNT_W_DEF-1:0] cnt_rst_val();
        return {CNT_W_DEF{1'b1}};
    endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Clock prescaler: emits a tick every prescale+1 enabled cycles.
module wdt_prescaler import wdt_pkg::*; #(
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q;

    // Exact-equality compare: lowering prescale below the current count wraps through 2^PRE_W.
    assign tick = enable && (pre_cnt_q == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else if (clear || tick) begin
            pre_cnt_q <= '0;
        end else if (enable) begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/wdt_timer_gen2.sv
// Watchdog counter core with prescaler, LOAD decode, interrupt clear and
// two-stage escalation from interrupt to sticky reset request.
module wdt_timer_gen2 import wdt_pkg::*; #(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PRE_W  = PRE_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [CNT_W-1:0]  pwdata,
    input  logic              lock,
    input  logic              stall,
    input  logic              int_en,
    input  logic              rst_en,
    input  logic              icr_wr,
    input  logic [PRE_W-1:0]  prescale,
    output logic [CNT_W-1:0]  cnt_value,
    output logic [CNT_W-1:0]  cnt_load,
    output logic              int_raw,
    output logic              rst_req,
    output logic              timeout_pulse
);

    localparam logic [CNT_W-1:0] CNT_RST = {CNT_W{1'b1}};

    wdt_state_e state;
    logic       tick;
    logic       load_wr;
    logic       timeout;

    assign load_wr = wr_en && (paddr == ADDR_W'(LOAD_ADDR)) && !lock;
    assign timeout = tick && (cnt_value == '0);

    wdt_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk      (pclk),
        .rst_n    (presetn),
        .clear    (load_wr || icr_wr),
        .enable   (int_en && !stall),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_value     <= CNT_RST;
            cnt_load      <= CNT_RST;
            int_raw       <= INT_RST;
            rst_req       <= REQ_RST;
            timeout_pulse <= 1'b0;
            state         <= STATE_RST;
        end else begin
            timeout_pulse <= 1'b0;

            if (load_wr) begin
                cnt_load  <= pwdata;
                cnt_value <= pwdata;
            end else if (icr_wr || timeout) begin
                cnt_value <= cnt_load;
            end else if (tick) begin
                cnt_value <= cnt_value - 1'b1;
            end

            // A coincident clear swallows the timeout: no pulse, no escalation.
            if (icr_wr) begin
                int_raw <= 1'b0;
                if (state == INT_PEND) begin
                    state <= ARMED;
                end
            end else if (timeout) begin
                timeout_pulse <= 1'b1;
                case (state)
                    ARMED: begin
                        state   <= INT_PEND;
                        int_raw <= 1'b1;
                    end
                    INT_PEND: begin
                        if (rst_en) begin
                            state   <= RST_ASSERTED;
                            rst_req <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wdt_timer_gen2.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural watchdog model.
module tb_wdt_timer_gen2;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PRE_W  = 8;
    localparam int unsigned ADDR_W = 12;
    localparam logic [66:0] RST_VEC = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000};

    logic              pclk;
    logic              presetn;
    logic              wr_en;
    logic [ADDR_W-1:0] paddr;
    logic [CNT_W-1:0]  pwdata;
    logic              lock;
    logic              stall;
    logic              int_en;
    logic              rst_en;
    logic              icr_wr;
    logic [PRE_W-1:0]  prescale;
    logic [CNT_W-1:0]  cnt_value;
    logic [CNT_W-1:0]  cnt_load;
    logic              int_raw;
    logic              rst_req;
    logic              timeout_pulse;

    int passed = 0;
    int total  = 0;

    wdt_timer_gen2 #(
        .CNT_W  (CNT_W),
        .PRE_W  (PRE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .wr_en         (wr_en),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .lock          (lock),
        .stall         (stall),
        .int_en        (int_en),
        .rst_en        (rst_en),
        .icr_wr        (icr_wr),
        .prescale      (prescale),
        .cnt_value     (cnt_value),
        .cnt_load      (cnt_load),
        .int_raw       (int_raw),
        .rst_req       (rst_req),
        .timeout_pulse (timeout_pulse)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: remaining ticks, reload value, ticks elapsed in the
    // current prescale period, and how many unserviced timeouts have occurred.
    logic [31:0] m_val;
    logic [31:0] m_load;
    logic [7:0]  m_pre;
    int          m_unserviced;
    logic        m_int;
    logic        m_rst;
    logic        m_pulse;

    wire [66:0] dut_vec = {cnt_value, cnt_load, int_raw, rst_req, timeout_pulse};

    function automatic logic [66:0] exp_vec();
        return {m_val, m_load, m_int, m_rst, m_pulse};
    endfunction

    task automatic model_reset();
        m_val        = 32'hFFFF_FFFF;
        m_load       = 32'hFFFF_FFFF;
        m_pre        = 8'd0;
        m_unserviced = 0;
        m_int        = 1'b0;
        m_rst        = 1'b0;
        m_pulse      = 1'b0;
    endtask

    task automatic model_step();
        bit running, tk, lw, to;
        running = int_en && !stall;
        tk      = running && (m_pre == prescale);
        lw      = wr_en && (paddr == 12'h000) && !lock;
        to      = tk && (m_val == 0);
        m_pulse = to && !icr_wr;

        if (lw || icr_wr || tk) m_pre = 8'd0;
        else if (running)       m_pre = m_pre + 8'd1;

        if (lw) begin
            m_load = pwdata;
            m_val  = pwdata;
        end else if (icr_wr || to) begin
            m_val = m_load;
        end else if (tk) begin
            m_val = m_val - 32'd1;
        end

        if (icr_wr) begin
            m_int = 1'b0;
            if (m_unserviced == 1) m_unserviced = 0;
        end else if (to) begin
            if (m_unserviced == 0) begin
                m_unserviced = 1;
                m_int        = 1'b1;
            end else if (m_unserviced == 1 && rst_en) begin
                m_unserviced = 2;
                m_rst        = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge pclk);
        if (presetn) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        lock     = 1'b0;
        stall    = 1'b0;
        int_en   = 1'b1;
        rst_en   = 1'b0;
        icr_wr   = 1'b0;
        prescale = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        presetn = 1'b0;
        model_reset();
        step();
        step();
        presetn = 1'b1;
    endtask

    task automatic write_load(input logic [31:0] v);
        wr_en  = 1'b1;
        paddr  = 12'h000;
        pwdata = v;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (dut_vec !== RST_VEC) $display("FAIL reset_state got=%h want=%h", dut_vec, RST_VEC);
        else passed++;
    endtask

    task automatic test_countdown();
        logic [31:0] seq [5];
        seq = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        do_reset();
        write_load(32'd5);
        total++;
        if (cnt_value !== 32'd5 || cnt_load !== 32'd5)
            $display("FAIL countdown_load got=%0d/%0d want=5/5", cnt_value, cnt_load);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (cnt_value !== seq[i] || timeout_pulse !== 1'b0 || dut_vec !== exp_vec())
                $display("FAIL countdown_val got=%0d want=%0d", cnt_value, seq[i]);
            else passed++;
        end
        step();
        total++;
        if (cnt_value !== 32'd5 || timeout_pulse !== 1'b1 || int_raw !== 1'b1 || rst_req !== 1'b0)
            $display("FAIL countdown_timeout got=%h want val=5 pulse=1 int=1 rst=0", dut_vec);
        else passed++;
    endtask

    task automatic test_prescale();
        logic [31:0] want;
        do_reset();
        prescale = 8'd3;
        write_load(32'd2);
        for (int c = 1; c <= 12; c++) begin
            step();
            want = (c < 4) ? 32'd2 : (c < 8) ? 32'd1 : (c < 12) ? 32'd0 : 32'd2;
            total++;
            if (cnt_value !== want || timeout_pulse !== (c == 12) || dut_vec !== exp_vec())
                $display("FAIL prescale_c%0d got=%0d pulse=%b want=%0d pulse=%b",
                         c, cnt_value, timeout_pulse, want, (c == 12));
            else passed++;
        end
    endtask

    task automatic test_escalation();
        int pulses = 0;
        do_reset();
        rst_en = 1'b1;
        write_load(32'd3);
        for (int i = 0; i < 40 && pulses < 2; i++) begin
            step();
            if (timeout_pulse === 1'b1) begin
                pulses++;
                total++;
                if (pulses == 1 && (int_raw !== 1'b1 || rst_req !== 1'b0))
                    $display("FAIL escalate_first got int=%b rst=%b want int=1 rst=0", int_raw, rst_req);
                else if (pulses == 2 && (int_raw !== 1'b1 || rst_req !== 1'b1))
                    $display("FAIL escalate_second got int=%b rst=%b want int=1 rst=1", int_raw, rst_req);
                else passed++;
            end
        end
        total++;
        if (pulses != 2) $display("FAIL escalate_timeouts got=%0d want=2", pulses);
        else passed++;
        icr_wr = 1'b1;
        step();
        icr_wr = 1'b0;
        total++;
        if (int_raw !== 1'b0 || rst_req !== 1'b1 || cnt_value !== 32'd3 || dut_vec !== exp_vec())
            $display("FAIL escalate_icr got int=%b rst=%b val=%0d want int=0 rst=1 val=3",
                     int_raw, rst_req, cnt_value);
        else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        lock = 1'b1;
        write_load(32'h10);
        total++;
        if (cnt_load !== 32'hFFFF_FFFF || cnt_value !== 32'hFFFF_FFFE)
            $display("FAIL lock_write got load=%h val=%h want load=ffffffff val=fffffffe",
                     cnt_load, cnt_value);
        else passed++;
        repeat (3) step();
        icr_wr = 1'b1;
        step();
        icr_wr = 1'b0;
        total++;
        if (cnt_value !== 32'hFFFF_FFFF || dut_vec !== exp_vec())
            $display("FAIL lock_icr got val=%h want=ffffffff", cnt_value);
        else passed++;
    endtask

    task automatic test_icr_collision();
        bit seen = 0;
        do_reset();
        rst_en = 1'b1;
        write_load(32'd3);
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = (timeout_pulse === 1'b1);
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = (cnt_value === 32'd0);
        end
        total++;
        if (!seen) $display("FAIL collide_reach_zero got val=%0d want=0", cnt_value);
        else passed++;
        icr_wr = 1'b1;
        step();
        icr_wr = 1'b0;
        total++;
        if (int_raw !== 1'b0 || rst_req !== 1'b0 || timeout_pulse !== 1'b0 || cnt_value !== 32'd3)
            $display("FAIL collide_clear got int=%b rst=%b pulse=%b val=%0d want 0/0/0/3",
                     int_raw, rst_req, timeout_pulse, cnt_value);
        else passed++;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = (timeout_pulse === 1'b1);
        end
        total++;
        if (!seen || int_raw !== 1'b1 || rst_req !== 1'b0)
            $display("FAIL collide_rearmed got int=%b rst=%b want int=1 rst=0", int_raw, rst_req);
        else passed++;
    endtask

    task automatic test_stall_and_reset();
        bit seen = 0;
        do_reset();
        prescale = 8'd1;
        write_load(32'd10);
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = (cnt_value === 32'd7);
        end
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (cnt_value !== 32'd7 || dut_vec !== exp_vec())
                $display("FAIL stall_hold got=%0d want=7", cnt_value);
            else passed++;
        end
        stall = 1'b0;
        step();
        total++;
        if (cnt_value !== 32'd7) $display("FAIL stall_release1 got=%0d want=7", cnt_value);
        else passed++;
        step();
        total++;
        if (cnt_value !== 32'd6) $display("FAIL stall_release2 got=%0d want=6", cnt_value);
        else passed++;
        #2;
        presetn = 1'b0;
        #1;
        total++;
        if (dut_vec !== RST_VEC) $display("FAIL async_reset got=%h want=%h", dut_vec, RST_VEC);
        else passed++;
        model_reset();
        step();
        presetn = 1'b1;
        step();
        total++;
        if (dut_vec !== exp_vec()) $display("FAIL after_reset got=%h want=%h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wr_en  = ($urandom_range(0, 24) == 0);
            paddr  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h000;
            pwdata = $urandom_range(0, 12);
            lock   = ($urandom_range(0, 3) == 0);
            stall  = ($urandom_range(0, 9) == 0);
            int_en = ($urandom_range(0, 9) != 0);
            rst_en = $urandom_range(0, 1);
            icr_wr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) prescale = 8'($urandom_range(0, 4));
            step();
            total++;
            if (dut_vec !== exp_vec())
                $display("FAIL random_c%0d got=%h want=%h", i, dut_vec, exp_vec());
            else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        presetn = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_countdown();
        test_prescale();
        test_escalation();
        test_lock();
        test_icr_collision();
        test_stall_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
